// File: rtl/load_align_unit.sv
// Sequential load-data unit: issues one or two aligned word reads per load, merges the
// beats of a boundary-straddling load, then shifts and sign/zero-extends the field.
module load_align_unit #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [2:0]            req_wid_i,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
    input  logic                  mem_rsp_valid_i,
    input  logic [DATA_WIDTH-1:0] mem_rsp_data_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  rsp_split_o,
    output logic                  rsp_err_o
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BYTES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ0  = 3'd1,
        S_WAIT0 = 3'd2,
        S_REQ1  = 3'd3,
        S_WAIT1 = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    function automatic logic [31:0] size_bytes(input logic [1:0] sz);
        logic [31:0] s;
        case (sz)
            2'b00:   s = 32'd1;
            2'b01:   s = 32'd2;
            2'b10:   s = 32'd4;
            2'b11:   s = 32'd8;
            default: s = 32'd1;
        endcase
        return s;
    endfunction

    function automatic logic is_illegal(input logic [2:0] wid);
        return (wid == 3'b111) || ((wid[1:0] == 2'b11) && (DATA_WIDTH < 64));
    endfunction

    function automatic logic crosses(input logic [OFF_W-1:0] off, input logic [2:0] wid);
        return (32'(off) + size_bytes(wid[1:0])) > 32'(BYTES);
    endfunction

    // Shift the two-beat window down to the field, then left/right shift to extend it.
    function automatic logic [DATA_WIDTH-1:0] extract(input logic [2*DATA_WIDTH-1:0] pair,
                                                      input logic [OFF_W-1:0]        off,
                                                      input logic [2:0]              wid);
        logic [2*DATA_WIDTH-1:0] w;
        logic [DATA_WIDTH-1:0]   lo;
        logic [31:0]             sh;
        w  = pair >> {off, 3'b000};
        lo = w[DATA_WIDTH-1:0];
        sh = 32'(DATA_WIDTH) - (size_bytes(wid[1:0]) << 3);
        lo = lo << sh;
        if (wid[2]) begin
            lo = lo >> sh;
        end else begin
            lo = $signed(lo) >>> sh;
        end
        return lo;
    endfunction

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [OFF_W-1:0]      off_q, off_d;
    logic [2:0]            wid_q, wid_d;
    logic                  split_q, split_d;
    logic [DATA_WIDTH-1:0] beat0_q, beat0_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_split_q, rsp_split_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  req_ready_q, req_ready_d;
    logic                  mem_req_valid_q, mem_req_valid_d;
    logic                  rsp_valid_q, rsp_valid_d;

    // Next-state, captured beats and the registered result.
    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        off_d       = off_q;
        wid_d       = wid_q;
        split_d     = split_q;
        beat0_d     = beat0_q;
        rsp_data_d  = rsp_data_q;
        rsp_split_d = rsp_split_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    mem_addr_d = {req_addr_i[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                    off_d      = req_addr_i[OFF_W-1:0];
                    wid_d      = req_wid_i;
                    if (is_illegal(req_wid_i)) begin
                        split_d     = 1'b0;
                        rsp_data_d  = {DATA_WIDTH{1'b0}};
                        rsp_split_d = 1'b0;
                        rsp_err_d   = 1'b1;
                        state_d     = S_RESP;
                    end else begin
                        split_d = crosses(req_addr_i[OFF_W-1:0], req_wid_i);
                        state_d = S_REQ0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ0: begin
                if (mem_req_ready_i) begin
                    state_d = S_WAIT0;
                end else begin
                    state_d = S_REQ0;
                end
            end
            S_WAIT0: begin
                if (mem_rsp_valid_i) begin
                    if (split_q) begin
                        beat0_d    = mem_rsp_data_i;
                        mem_addr_d = mem_addr_q + ADDR_WIDTH'(BYTES);
                        state_d    = S_REQ1;
                    end else begin
                        rsp_data_d  = extract({{DATA_WIDTH{1'b0}}, mem_rsp_data_i}, off_q, wid_q);
                        rsp_split_d = 1'b0;
                        rsp_err_d   = 1'b0;
                        state_d     = S_RESP;
                    end
                end else begin
                    state_d = S_WAIT0;
                end
            end
            S_REQ1: begin
                if (mem_req_ready_i) begin
                    state_d = S_WAIT1;
                end else begin
                    state_d = S_REQ1;
                end
            end
            S_WAIT1: begin
                if (mem_rsp_valid_i) begin
                    rsp_data_d  = extract({mem_rsp_data_i, beat0_q}, off_q, wid_q);
                    rsp_split_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    state_d     = S_RESP;
                end else begin
                    state_d = S_WAIT1;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        req_ready_d     = (state_d == S_IDLE);
        mem_req_valid_d = (state_d == S_REQ0) || (state_d == S_REQ1);
        rsp_valid_d     = (state_d == S_RESP);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= S_IDLE;
            mem_addr_q      <= {ADDR_WIDTH{1'b0}};
            off_q           <= {OFF_W{1'b0}};
            wid_q           <= 3'b000;
            split_q         <= 1'b0;
            beat0_q         <= {DATA_WIDTH{1'b0}};
            rsp_data_q      <= {DATA_WIDTH{1'b0}};
            rsp_split_q     <= 1'b0;
            rsp_err_q       <= 1'b0;
            req_ready_q     <= 1'b1;
            mem_req_valid_q <= 1'b0;
            rsp_valid_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            mem_addr_q      <= mem_addr_d;
            off_q           <= off_d;
            wid_q           <= wid_d;
            split_q         <= split_d;
            beat0_q         <= beat0_d;
            rsp_data_q      <= rsp_data_d;
            rsp_split_q     <= rsp_split_d;
            rsp_err_q       <= rsp_err_d;
            req_ready_q     <= req_ready_d;
            mem_req_valid_q <= mem_req_valid_d;
            rsp_valid_q     <= rsp_valid_d;
        end
    end

    assign req_ready_o     = req_ready_q;
    assign mem_req_valid_o = mem_req_valid_q;
    assign mem_req_addr_o  = mem_addr_q;
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_data_o      = rsp_data_q;
    assign rsp_split_o     = rsp_split_q;
    assign rsp_err_o       = rsp_err_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: table of hand-computed loads against a small memory
// responder with configurable request stalls, plus illegal-width, backpressure and reset cases.
module tb_load_align_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [63:0] req_addr_i = 64'h0;
    logic [2:0]  req_wid_i = 3'b000;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i = 1'b1;
    logic [63:0] mem_req_addr_o;
    logic        mem_rsp_valid_i = 1'b0;
    logic [63:0] mem_rsp_data_i = 64'h0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b1;
    logic [63:0] rsp_data_o;
    logic        rsp_split_o;
    logic        rsp_err_o;

    load_align_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_wid_i(req_wid_i),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_addr_o(mem_req_addr_o),
        .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_data_i(mem_rsp_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_data_o(rsp_data_o), .rsp_split_o(rsp_split_o), .rsp_err_o(rsp_err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic [63:0] mem_words [logic [63:0]];
    logic [63:0] addr_log [$];
    logic [63:0] mute_addr = 64'h1;
    int          stall_cfg = 0;
    int          stale_req = 0;
    int          stale_done = 0;

    // Memory responder: stalls each read stall_cfg cycles, answers the cycle after acceptance.
    initial begin
        int          stall_cnt = 0;
        bit          hs;
        bit          prev_stalled = 1'b0;
        logic [63:0] prev_addr = 64'h0;
        logic [63:0] hs_addr = 64'h0;
        forever begin
            @(negedge clk_i);
            hs = 1'b0;
            if (mem_req_valid_o) begin
                if (prev_stalled) check_eq("addr_hold", mem_req_addr_o, prev_addr);
                if (stall_cnt < stall_cfg) begin
                    mem_req_ready_i = 1'b0;
                    stall_cnt++;
                    prev_stalled = 1'b1;
                end else begin
                    mem_req_ready_i = 1'b1;
                    stall_cnt = 0;
                    prev_stalled = 1'b0;
                    hs = 1'b1;
                    hs_addr = mem_req_addr_o;
                    addr_log.push_back(mem_req_addr_o);
                end
                prev_addr = mem_req_addr_o;
            end else begin
                if (prev_stalled) check_eq("valid_hold", 64'(mem_req_valid_o), 64'h1);
                mem_req_ready_i = 1'b1;
                stall_cnt = 0;
                prev_stalled = 1'b0;
            end
            @(posedge clk_i);
            #1;
            if (hs && hs_addr != mute_addr) begin
                mem_rsp_valid_i = 1'b1;
                mem_rsp_data_i = mem_words.exists(hs_addr) ? mem_words[hs_addr] : 64'h0;
            end else if (stale_req != stale_done) begin
                mem_rsp_valid_i = 1'b1;
                mem_rsp_data_i = 64'hDEAD_BEEF_DEAD_BEEF;
                stale_done++;
            end else begin
                mem_rsp_valid_i = 1'b0;
            end
        end
    end

    task automatic issue(input logic [63:0] a, input logic [2:0] w, output int lat,
                         output logic busy_ready);
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_addr_i  = a;
        req_wid_i   = w;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        lat = 0;
        busy_ready = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk_i);
            lat++;
            if (lat == 1) busy_ready = req_ready_o;
            if (rsp_valid_o) break;
        end
    endtask

    typedef struct {
        logic [63:0] addr;
        logic [2:0]  wid;
        int          stall;
        logic [63:0] a0, m0, a1, m1, exp;
        logic        sp;
        int          lat;
        int          nr;
    } vec_t;

    vec_t vt[14];

    initial begin
        int          lat;
        int          n0;
        logic        busy;
        logic [63:0] ff8;
        ff8 = 64'hFFFF_FFFF_FFFF_FFF8;
        vt[0]  = '{64'h10, 3'b000, 0, 64'h10, 64'h0123_4567_89AB_CD80, 64'h18, 64'h0,
                   64'hFFFF_FFFF_FFFF_FF80, 1'b0, 3, 1};
        vt[1]  = '{64'h13, 3'b101, 0, 64'h10, 64'h0000_00AB_CD00_0000, 64'h18, 64'h0,
                   64'h0000_0000_0000_ABCD, 1'b0, 3, 1};
        vt[2]  = '{64'h0E, 3'b010, 0, 64'h08, 64'h3412_DEAD_BEEF_0011, 64'h10, 64'h7766_5544_3322_8856,
                   64'hFFFF_FFFF_8856_3412, 1'b1, 5, 2};
        vt[3]  = '{64'h0F, 3'b011, 2, 64'h08, 64'hA1B2_C3D4_E5F6_0718, 64'h10, 64'h1122_3344_5566_7788,
                   64'h2233_4455_6677_88A1, 1'b1, 9, 2};
        vt[4]  = '{64'h47, 3'b100, 0, 64'h40, 64'h8877_6655_F4F3_F2F1, 64'h48, 64'hC3,
                   64'h0000_0000_0000_0088, 1'b0, 3, 1};
        vt[5]  = '{64'h46, 3'b001, 0, 64'h40, 64'h8877_6655_F4F3_F2F1, 64'h48, 64'hC3,
                   64'hFFFF_FFFF_FFFF_8877, 1'b0, 3, 1};
        vt[6]  = '{64'h40, 3'b110, 0, 64'h40, 64'h8877_6655_F4F3_F2F1, 64'h48, 64'hC3,
                   64'h0000_0000_F4F3_F2F1, 1'b0, 3, 1};
        vt[7]  = '{64'h44, 3'b010, 0, 64'h40, 64'h8877_6655_F4F3_F2F1, 64'h48, 64'hC3,
                   64'hFFFF_FFFF_8877_6655, 1'b0, 3, 1};
        vt[8]  = '{64'h40, 3'b011, 0, 64'h40, 64'h8877_6655_F4F3_F2F1, 64'h48, 64'hC3,
                   64'h8877_6655_F4F3_F2F1, 1'b0, 3, 1};
        vt[9]  = '{64'h41, 3'b000, 0, 64'h40, 64'h8877_6655_F4F3_F2F1, 64'h48, 64'hC3,
                   64'hFFFF_FFFF_FFFF_FFF2, 1'b0, 3, 1};
        vt[10] = '{64'h45, 3'b010, 0, 64'h40, 64'h8877_6655_F4F3_F2F1, 64'h48, 64'hC3,
                   64'hFFFF_FFFF_C388_7766, 1'b1, 5, 2};
        vt[11] = '{64'h47, 3'b101, 0, 64'h40, 64'h8877_6655_F4F3_F2F1, 64'h48, 64'hC3,
                   64'h0000_0000_0000_C388, 1'b1, 5, 2};
        vt[12] = '{64'hFFFF_FFFF_FFFF_FFFF, 3'b001, 0, ff8, 64'h5A00_0000_0000_0000, 64'h0, 64'hE1,
                   64'hFFFF_FFFF_FFFF_E15A, 1'b1, 5, 2};
        vt[13] = '{64'h42, 3'b101, 1, 64'h40, 64'h8877_6655_F4F3_F2F1, 64'h48, 64'hC3,
                   64'h0000_0000_0000_F4F3, 1'b0, 4, 1};

        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check_eq("rst_req_ready", 64'(req_ready_o), 64'h1);
        check_eq("rst_mem_valid", 64'(mem_req_valid_o), 64'h0);
        check_eq("rst_rsp_valid", 64'(rsp_valid_o), 64'h0);
        check_eq("rst_rsp_data", rsp_data_o, 64'h0);
        check_eq("rst_split_err", {62'h0, rsp_split_o, rsp_err_o}, 64'h0);

        foreach (vt[i]) begin
            mem_words[vt[i].a0] = vt[i].m0;
            mem_words[vt[i].a1] = vt[i].m1;
            stall_cfg = vt[i].stall;
            n0 = addr_log.size();
            issue(vt[i].addr, vt[i].wid, lat, busy);
            check_eq($sformatf("v%0d_data", i), rsp_data_o, vt[i].exp);
            check_eq($sformatf("v%0d_split", i), 64'(rsp_split_o), 64'(vt[i].sp));
            check_eq($sformatf("v%0d_err", i), 64'(rsp_err_o), 64'h0);
            check_eq($sformatf("v%0d_lat", i), 64'(lat), 64'(vt[i].lat));
            check_eq($sformatf("v%0d_busy", i), 64'(busy), 64'h0);
            check_eq($sformatf("v%0d_nreads", i), 64'(addr_log.size() - n0), 64'(vt[i].nr));
            if (addr_log.size() > n0) check_eq($sformatf("v%0d_a0", i), addr_log[n0], vt[i].a0);
            if (vt[i].nr == 2 && addr_log.size() > n0 + 1)
                check_eq($sformatf("v%0d_a1", i), addr_log[n0+1], vt[i].a1);
            @(negedge clk_i);
            check_eq($sformatf("v%0d_idle", i), {62'h0, rsp_valid_o, req_ready_o}, 64'h1);
            check_eq($sformatf("v%0d_hold", i), rsp_data_o, vt[i].exp);
        end
        stall_cfg = 0;

        // Illegal width under result backpressure.
        rsp_ready_i = 1'b0;
        n0 = addr_log.size();
        issue(64'h20, 3'b111, lat, busy);
        check_eq("ill_lat", 64'(lat), 64'h1);
        check_eq("ill_err", 64'(rsp_err_o), 64'h1);
        check_eq("ill_data", rsp_data_o, 64'h0);
        check_eq("ill_split", 64'(rsp_split_o), 64'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            check_eq("ill_stable", {rsp_data_o[61:0], rsp_valid_o, rsp_err_o}, 64'h3);
            check_eq("ill_no_accept", 64'(req_ready_o), 64'h0);
        end
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        check_eq("ill_idle", {62'h0, rsp_valid_o, req_ready_o}, 64'h1);
        check_eq("ill_noread", 64'(addr_log.size() - n0), 64'h0);

        // Reset while waiting on the second beat, whose response is withheld.
        mem_words[64'h10] = 64'h1111_2222_3333_4444;
        mem_words[64'h18] = 64'h5555_6666_7777_8888;
        mute_addr = 64'h18;
        n0 = addr_log.size();
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_addr_i  = 64'h14;
        req_wid_i   = 3'b011;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk_i);
            #2;
            if (addr_log.size() >= n0 + 2) break;
        end
        check_eq("rst6_reads", 64'(addr_log.size() - n0), 64'h2);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check_eq("rst6_ready", 64'(req_ready_o), 64'h1);
        check_eq("rst6_rsp_valid", 64'(rsp_valid_o), 64'h0);
        check_eq("rst6_mem_valid", 64'(mem_req_valid_o), 64'h0);
        stale_req++;
        repeat (3) @(negedge clk_i);
        check_eq("stale_ignored", {61'h0, rsp_valid_o, mem_req_valid_o, req_ready_o}, 64'h1);
        mute_addr = 64'h1;
        mem_words[64'h28] = 64'h0123_4567_CAFE_F00D;
        n0 = addr_log.size();
        issue(64'h28, 3'b110, lat, busy);
        check_eq("post_rst_data", rsp_data_o, 64'h0000_0000_CAFE_F00D);
        check_eq("post_rst_lat", 64'(lat), 64'h3);
        check_eq("post_rst_addr", (addr_log.size() > n0) ? addr_log[n0] : 64'hX, 64'h28);

        @(negedge clk_i);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
